johnson_phase_decoder: RTL

- Downstream consumer of the synchronous Johnson (twisted-ring) counter.
- Samples the counter's N stage outputs every clock and decodes the 2N-state code into a binary phase index and a one-hot phase vector.
- Checks each step for legality, declares lock after a run of correct successor steps, counts completed revolutions, and flags illegal or out-of-sequence codes.
- Used wherever the counter drives multiphase timing or sequencing logic.

---
 rtl/johnson_phase_decoder_if.sv | 28 ++
 rtl/johnson_phase_decoder.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/johnson_phase_decoder_if.sv
// Bundle between a Johnson counter sampler and its consumer: the raw stage
// code and error clear in, the decoded phase and tracking status out.
interface johnson_phase_decoder_if #(
  parameter int N  = 4,
  parameter int CW = 8
);
  localparam int PW = $clog2(2 * N);

  logic [N-1:0]   q;
  logic           err_clr;
  logic [PW-1:0]  phase;
  logic [2*N-1:0] onehot;
  logic           phase_valid;
  logic           locked;
  logic           wrap;
  logic [CW-1:0]  rev_count;
  logic           illegal;

  modport master (
    output q, err_clr,
    input  phase, onehot, phase_valid, locked, wrap, rev_count, illegal
  );

  modport slave (
    input  q, err_clr,
    output phase, onehot, phase_valid, locked, wrap, rev_count, illegal
  );
endinterface

// File: rtl/johnson_phase_decoder.sv
// Decodes a sampled N-stage Johnson code into a phase index and one-hot vector,
// tracks step legality to establish lock, and counts completed revolutions.
module johnson_phase_decoder #(
  parameter int N        = 4,
  parameter int LOCK_CNT = 3,
  parameter int CW       = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  johnson_phase_decoder_if.slave  bus
);
  localparam int S  = 2 * N;
  localparam int PW = $clog2(S);

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_e;

  function automatic logic [N-1:0] code_of(input int k);
    logic [N-1:0] c;
    for (int i = 0; i < N; i++) begin
      if (k <= N) c[i] = (i < k);
      else        c[i] = (i >= k - N);
    end
    return c;
  endfunction

  // {legal, index}; index is zero when the code matches no state
  function automatic logic [PW:0] decode(input logic [N-1:0] c);
    logic [PW:0] r;
    r = '0;
    for (int k = 0; k < S; k++) begin
      if (c == code_of(k)) r = {1'b1, PW'(k)};
    end
    return r;
  endfunction

  state_e         state_q;
  logic [3:0]     run_q;
  logic [N-1:0]   prev_q;
  logic           first_q;
  logic [PW-1:0]  phase_q;
  logic [S-1:0]   onehot_q;
  logic           valid_q;
  logic           locked_q;
  logic           wrap_q;
  logic [CW-1:0]  rev_q;
  logic           illegal_q;

  logic           cur_legal, prev_legal;
  logic [PW-1:0]  cur_ph, prev_ph, succ_ph;
  logic           adv, hold, ill, bad;
  logic           wrap_d, illegal_set;

  always_comb begin
    {cur_legal, cur_ph}   = decode(bus.q);
    {prev_legal, prev_ph} = decode(prev_q);
    succ_ph = (prev_ph == PW'(S - 1)) ? '0 : prev_ph + 1'b1;
    ill  = !cur_legal;
    // Right after reset there is no real predecessor, so a legal code just holds
    hold = cur_legal && (first_q || (bus.q == prev_q));
    adv  = cur_legal && prev_legal && !first_q && (cur_ph == succ_ph);
    bad  = !ill && !hold && !adv;
    wrap_d = adv && (prev_ph == PW'(S - 1)) && (cur_ph == '0) && (state_q == LOCKED);
    illegal_set = ill || (bad && (state_q == LOCKED));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SEARCH;
      run_q     <= '0;
      prev_q    <= '0;
      first_q   <= 1'b1;
      phase_q   <= '0;
      onehot_q  <= '0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
      wrap_q    <= 1'b0;
      rev_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      first_q <= 1'b0;
      prev_q  <= bus.q;
      valid_q <= cur_legal;
      if (cur_legal) begin
        phase_q  <= cur_ph;
        onehot_q <= {{(S-1){1'b0}}, 1'b1} << cur_ph;
      end else begin
        onehot_q <= '0;
      end
      wrap_q <= wrap_d;
      if (wrap_d) rev_q <= rev_q + 1'b1;
      if (illegal_set)      illegal_q <= 1'b1;
      else if (bus.err_clr) illegal_q <= 1'b0;

      case (state_q)
        SEARCH: begin
          if (adv) begin
            run_q <= 4'd1;
            if (LOCK_CNT == 1) begin
              state_q  <= LOCKED;
              locked_q <= 1'b1;
            end else begin
              state_q <= TRACK;
            end
          end
        end
        TRACK: begin
          if (adv) begin
            run_q <= run_q + 4'd1;
            if (run_q + 4'd1 == 4'(LOCK_CNT)) begin
              state_q  <= LOCKED;
              locked_q <= 1'b1;
            end
          end else if (!hold) begin
            state_q <= SEARCH;
            run_q   <= '0;
          end
        end
        LOCKED: begin
          if (!adv && !hold) begin
            state_q  <= SEARCH;
            run_q    <= '0;
            locked_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= SEARCH;
          run_q    <= '0;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.phase       = phase_q;
  assign bus.onehot      = onehot_q;
  assign bus.phase_valid = valid_q;
  assign bus.locked      = locked_q;
  assign bus.wrap        = wrap_q;
  assign bus.rev_count   = rev_q;
  assign bus.illegal     = illegal_q;
endmodule
